// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: MIPS ExcCodes, FSM states,
// the priority-encoder result bundle and the EPC adjustment helper.
package exception_sequencer_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } seq_state_t;

  // flush bit order: [0]=IF [1]=ID [2]=EX [3]=M
  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [3:0]  flush;
  } exc_sel_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_adjust(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Bundle between pipeline/CP0 (master) and the exception sequencer (slave).
interface exception_sequencer_if;
  // Handshake: Exc_Req rises the cycle after a flag is accepted and stays high
  // until Exc_Ack is sampled high on a rising edge (or the ack timeout expires);
  // Exc_Ack seen while Exc_Req is low is ignored.
  logic        Stall;
  logic        EXC_AdIF, EXC_Sys, EXC_Bp, EXC_RI, EXC_Ov, EXC_Tr, EXC_AdEL, EXC_AdES;
  logic        Int_Pend;
  logic [31:0] IF_PC, ID_PC, EX_PC, M_PC;
  logic        ID_BD, EX_BD, M_BD;
  logic        Exc_Ack;
  logic        Flush_IF, Flush_ID, Flush_EX, Flush_M;
  logic        Exc_Stall, Exc_Req;
  logic [4:0]  Exc_Code;
  logic [31:0] Exc_EPC;
  logic        Exc_BD;
  logic        Exc_Redirect;
  logic [31:0] Exc_Vector;
  logic        Exc_Timeout;

  modport master (
    output Stall, EXC_AdIF, EXC_Sys, EXC_Bp, EXC_RI, EXC_Ov, EXC_Tr, EXC_AdEL, EXC_AdES,
           Int_Pend, IF_PC, ID_PC, EX_PC, M_PC, ID_BD, EX_BD, M_BD, Exc_Ack,
    input  Flush_IF, Flush_ID, Flush_EX, Flush_M, Exc_Stall, Exc_Req, Exc_Code, Exc_EPC,
           Exc_BD, Exc_Redirect, Exc_Vector, Exc_Timeout
  );

  modport slave (
    input  Stall, EXC_AdIF, EXC_Sys, EXC_Bp, EXC_RI, EXC_Ov, EXC_Tr, EXC_AdEL, EXC_AdES,
           Int_Pend, IF_PC, ID_PC, EX_PC, M_PC, ID_BD, EX_BD, M_BD, Exc_Ack,
    output Flush_IF, Flush_ID, Flush_EX, Flush_M, Exc_Stall, Exc_Req, Exc_Code, Exc_EPC,
           Exc_BD, Exc_Redirect, Exc_Vector, Exc_Timeout
  );
endinterface

// File: rtl/exc_priority_enc.sv
// Combinational oldest-first exception selection: picks the stage, ExcCode,
// EPC/BD and the mask of stages to kill (selected stage and everything younger).
module exc_priority_enc
  import exception_sequencer_pkg::*;
(
  input  logic        adif,
  input  logic        sys,
  input  logic        bp,
  input  logic        ri,
  input  logic        ov,
  input  logic        tr,
  input  logic        adel,
  input  logic        ades,
  input  logic        int_pend,
  input  logic [31:0] if_pc,
  input  logic [31:0] id_pc,
  input  logic [31:0] ex_pc,
  input  logic [31:0] m_pc,
  input  logic        id_bd,
  input  logic        ex_bd,
  input  logic        m_bd,
  output exc_sel_t    sel
);

  always_comb begin
    sel = '0;
    if (adel || ades || int_pend) begin
      sel.valid = 1'b1;
      sel.code  = adel ? EXC_ADEL : (ades ? EXC_ADES : EXC_INT);
      sel.epc   = epc_adjust(m_pc, m_bd);
      sel.bd    = m_bd;
      sel.flush = 4'b1111;
    end else if (ov || tr) begin
      sel.valid = 1'b1;
      sel.code  = ov ? EXC_OV : EXC_TR;
      sel.epc   = epc_adjust(ex_pc, ex_bd);
      sel.bd    = ex_bd;
      sel.flush = 4'b0111;
    end else if (sys || bp || ri) begin
      sel.valid = 1'b1;
      sel.code  = sys ? EXC_SYS : (bp ? EXC_BP : EXC_RI);
      sel.epc   = epc_adjust(id_pc, id_bd);
      sel.bd    = id_bd;
      sel.flush = 4'b0011;
    end else if (adif) begin
      // IF has no delay-slot information; fetch faults report the raw PC.
      sel.valid = 1'b1;
      sel.code  = EXC_ADEL;
      sel.epc   = if_pc;
      sel.bd    = 1'b0;
      sel.flush = 4'b0001;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: accepts the oldest exception, holds a CP0 write request
// until ack or timeout, then issues a one-cycle redirect to the exception vector.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h80000180,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  exception_sequencer_if.slave bus,
  output seq_state_t           debug_state
);

  localparam int            CW       = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  seq_state_t    state, state_nxt;
  exc_sel_t      sel;
  logic [4:0]    code_q;
  logic [31:0]   epc_q;
  logic          bd_q;
  logic [3:0]    flush_q;
  logic [CW-1:0] cnt;
  logic          timeout_q;
  logic          accept, expire;
  logic [3:0]    flush_vec;
  logic          req, stall_o, redirect;

  exc_priority_enc u_prio (
    .adif     (bus.EXC_AdIF),
    .sys      (bus.EXC_Sys),
    .bp       (bus.EXC_Bp),
    .ri       (bus.EXC_RI),
    .ov       (bus.EXC_Ov),
    .tr       (bus.EXC_Tr),
    .adel     (bus.EXC_AdEL),
    .ades     (bus.EXC_AdES),
    .int_pend (bus.Int_Pend),
    .if_pc    (bus.IF_PC),
    .id_pc    (bus.ID_PC),
    .ex_pc    (bus.EX_PC),
    .m_pc     (bus.M_PC),
    .id_bd    (bus.ID_BD),
    .ex_bd    (bus.EX_BD),
    .m_bd     (bus.M_BD),
    .sel      (sel)
  );

  assign accept = (state == ST_IDLE) && !bus.Stall && sel.valid;
  assign expire = (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_COMMIT;
      ST_COMMIT:   if (bus.Exc_Ack || expire) state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_vec = 4'b0000;
    req       = 1'b0;
    stall_o   = 1'b0;
    redirect  = 1'b0;
    case (state)
      ST_IDLE:     if (accept) flush_vec = sel.flush;
      ST_COMMIT: begin
        flush_vec = flush_q;
        req       = 1'b1;
        stall_o   = 1'b1;
      end
      ST_REDIRECT: begin
        flush_vec = 4'b0001;
        stall_o   = 1'b1;
        redirect  = 1'b1;
      end
      default: ;
    endcase
  end

  // Holding registers, ack-timeout counter and the sticky timeout flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q    <= '0;
      epc_q     <= '0;
      bd_q      <= 1'b0;
      flush_q   <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        code_q  <= sel.code;
        epc_q   <= sel.epc;
        bd_q    <= sel.bd;
        flush_q <= sel.flush;
      end
      if (state == ST_COMMIT) begin
        cnt <= cnt + CW'(1);
        // A same-cycle ack wins over the timeout.
        if (!bus.Exc_Ack && expire) timeout_q <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.Flush_IF     = flush_vec[0];
  assign bus.Flush_ID     = flush_vec[1];
  assign bus.Flush_EX     = flush_vec[2];
  assign bus.Flush_M      = flush_vec[3];
  assign bus.Exc_Req      = req;
  assign bus.Exc_Stall    = stall_o;
  assign bus.Exc_Redirect = redirect;
  assign bus.Exc_Code     = code_q;
  assign bus.Exc_EPC      = epc_q;
  assign bus.Exc_BD       = bd_q;
  assign bus.Exc_Vector   = EXC_VECTOR;
  assign bus.Exc_Timeout  = timeout_q;
  assign debug_state      = state;

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer against a table-driven model of
// the oldest-first selection rules and the req/ack/redirect timing.
module tb_exception_sequencer
  import exception_sequencer_pkg::*;
;

  logic       clock;
  logic       reset;
  seq_state_t debug_state;
  int         total;
  int         bad;

  exception_sequencer_if bus();

  exception_sequencer #(.EXC_VECTOR(32'h80000180), .ACK_TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .debug_state (debug_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flag index order = priority order: AdEL AdES Int Ov Tr Sys Bp RI AdIF
  int          code_tbl  [9] = '{4, 5, 0, 12, 13, 8, 9, 10, 4};
  int          stage_tbl [9] = '{3, 3, 3, 2, 2, 1, 1, 1, 0};
  logic [31:0] stage_pc  [4];
  logic        stage_bd  [4];
  logic [8:0]  cur_flags;

  wire [3:0] flush_obs = {bus.Flush_M, bus.Flush_EX, bus.Flush_ID, bus.Flush_IF};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_inputs(input logic [8:0] fl);
    cur_flags    = fl;
    bus.EXC_AdEL = fl[0];
    bus.EXC_AdES = fl[1];
    bus.Int_Pend = fl[2];
    bus.EXC_Ov   = fl[3];
    bus.EXC_Tr   = fl[4];
    bus.EXC_Sys  = fl[5];
    bus.EXC_Bp   = fl[6];
    bus.EXC_RI   = fl[7];
    bus.EXC_AdIF = fl[8];
    bus.IF_PC    = stage_pc[0];
    bus.ID_PC    = stage_pc[1];
    bus.EX_PC    = stage_pc[2];
    bus.M_PC     = stage_pc[3];
    bus.ID_BD    = stage_bd[1];
    bus.EX_BD    = stage_bd[2];
    bus.M_BD     = stage_bd[3];
  endtask

  task automatic randomize_pcs();
    for (int s = 0; s < 4; s++) begin
      stage_pc[s] = {$urandom()} & 32'hFFFF_FFFC;
      stage_bd[s] = (s == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  endtask

  // Reference: first set flag in priority order decides stage, code and EPC.
  task automatic model(input logic [8:0] fl, output logic [4:0] code, output logic [31:0] epc,
                       output logic bd, output logic [3:0] mask);
    int s;
    s = -1;
    code = '0;
    for (int i = 0; i < 9; i++) begin
      if (fl[i] && s < 0) begin
        s    = stage_tbl[i];
        code = 5'(code_tbl[i]);
      end
    end
    if (s < 0) s = 0;
    bd   = stage_bd[s];
    epc  = stage_pc[s] - (bd ? 32'd4 : 32'd0);
    mask = 4'((1 << (s + 1)) - 1);
  endtask

  // One full exception: accept, COMMIT for ack_delay+1 cycles, ack, redirect.
  task automatic exercise(input logic [8:0] fl, input int ack_delay);
    logic [4:0]  ec;
    logic [31:0] ee;
    logic        eb;
    logic [3:0]  em;
    logic [43:0] exp_v;
    logic [43:0] got_v;
    bus.Stall = 1'b0;
    apply_inputs(fl);
    model(fl, ec, ee, eb, em);
    @(negedge clock);
    total++;
    if ({bus.Exc_Req, bus.Exc_Redirect, flush_obs} !== {2'b00, em}) begin
      bad++;
      $display("FAIL accept fl=%b got req/redir/flush=%b exp=%b", fl,
               {bus.Exc_Req, bus.Exc_Redirect, flush_obs}, {2'b00, em});
    end
    tick();
    randomize_pcs();
    apply_inputs(9'h0);
    exp_v = {1'b1, 1'b1, 1'b0, em, ec, ee, eb};
    for (int d = 0; d <= ack_delay; d++) begin
      @(negedge clock);
      got_v = {bus.Exc_Req, bus.Exc_Stall, bus.Exc_Redirect, flush_obs,
               bus.Exc_Code, bus.Exc_EPC, bus.Exc_BD};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL commit fl=%b d=%0d got=%h exp=%h", fl, d, got_v, exp_v);
      end
      if (d == ack_delay) bus.Exc_Ack = 1'b1;
      tick();
    end
    bus.Exc_Ack = 1'b0;
    @(negedge clock);
    got_v = {bus.Exc_Req, bus.Exc_Stall, bus.Exc_Redirect, flush_obs, 32'h0, bus.Exc_Vector};
    exp_v = {1'b0, 1'b1, 1'b1, 4'b0001, 32'h0, 32'h80000180};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL redirect fl=%b got=%h exp=%h", fl, got_v, exp_v);
    end
    tick();
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if ({bus.Exc_Req, bus.Exc_Stall, bus.Exc_Redirect, flush_obs, bus.Exc_Code, bus.Exc_EPC,
         bus.Exc_BD, bus.Exc_Timeout, bus.Exc_Vector} !== {11'h0, 32'h0, 2'b00, 32'h80000180}) begin
      bad++;
      $display("FAIL reset_outputs got code=%0d epc=%h vec=%h req=%b", bus.Exc_Code, bus.Exc_EPC,
               bus.Exc_Vector, bus.Exc_Req);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (debug_state !== ST_IDLE || bus.Exc_Req !== 1'b0 || bus.Exc_Timeout !== 1'b0) begin
      bad++;
      $display("FAIL after_reset got state=%0d req=%b to=%b exp 0 0 0", debug_state,
               bus.Exc_Req, bus.Exc_Timeout);
    end
    tick();
  endtask

  task automatic test_idle_ack();
    bus.Exc_Ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++;
      if (bus.Exc_Req !== 1'b0 || bus.Exc_Redirect !== 1'b0 || debug_state !== ST_IDLE) begin
        bad++;
        $display("FAIL idle_ack got req=%b redir=%b exp 0 0", bus.Exc_Req, bus.Exc_Redirect);
      end
      tick();
    end
    bus.Exc_Ack = 1'b0;
  endtask

  task automatic test_directed();
    stage_pc[2] = 32'h0040_0010; stage_bd[2] = 1'b0;
    exercise(9'b0_0001_0000, 0);                 // trap in EX
    stage_pc[2] = 32'h0040_0024; stage_bd[2] = 1'b1;
    exercise(9'b0_0000_1000, 2);                 // overflow in delay slot
    stage_pc[3] = 32'h0040_1000; stage_bd[3] = 1'b0;
    exercise(9'b0_0011_0001, 1);                 // AdEL + Tr + Sys
    stage_pc[0] = 32'h0040_2004;
    exercise(9'b1_0000_0000, 0);                 // fetch fault only
  endtask

  task automatic test_stall();
    randomize_pcs();
    bus.Stall = 1'b1;
    apply_inputs(9'b0_0011_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if ({bus.Exc_Req, flush_obs} !== 5'b0 || debug_state !== ST_IDLE) begin
        bad++;
        $display("FAIL stall_ignore cyc=%0d got req/flush=%b exp=00000", i, {bus.Exc_Req, flush_obs});
      end
      tick();
    end
    exercise(9'b0_0011_0000, 1);
  endtask

  task automatic test_back_to_back();
    randomize_pcs();
    exercise(9'b0_0100_0000, 0);
    exercise(9'b0_0000_0100, 3);
    exercise(9'b0_1000_0000, 0);
  endtask

  task automatic test_timeout();
    logic [2:0] exp_v;
    randomize_pcs();
    bus.Stall = 1'b0;
    apply_inputs(9'b0_0001_0000);
    @(negedge clock);
    tick();
    apply_inputs(9'h0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clock);
      exp_v = (c == 17) ? 3'b011 : 3'b100;
      total++;
      if ({bus.Exc_Req, bus.Exc_Redirect, bus.Exc_Timeout} !== exp_v) begin
        bad++;
        $display("FAIL timeout c=%0d got req/redir/to=%b exp=%b", c,
                 {bus.Exc_Req, bus.Exc_Redirect, bus.Exc_Timeout}, exp_v);
      end
      tick();
    end
    exercise(9'b0_0000_0010, 0);
    @(negedge clock);
    total++;
    if (bus.Exc_Timeout !== 1'b1 || debug_state !== ST_IDLE) begin
      bad++;
      $display("FAIL timeout_sticky got to=%b state=%0d exp 1 0", bus.Exc_Timeout, debug_state);
    end
    tick();
  endtask

  task automatic test_reset_mid_commit();
    randomize_pcs();
    bus.Stall = 1'b0;
    apply_inputs(9'b0_0000_1000);
    @(negedge clock);
    tick();
    apply_inputs(9'h0);
    @(negedge clock);
    total++;
    if (bus.Exc_Req !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_req got=%b exp=1", bus.Exc_Req);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.Exc_Req, bus.Exc_Redirect, bus.Exc_Timeout} !== 3'b000 || debug_state !== ST_IDLE) begin
      bad++;
      $display("FAIL async_reset got req/redir/to=%b state=%0d exp 000 0",
               {bus.Exc_Req, bus.Exc_Redirect, bus.Exc_Timeout}, debug_state);
    end
    tick();
    reset = 1'b0;
    exercise(9'b0_0001_0000, 2);
  endtask

  task automatic test_ack_at_timeout();
    randomize_pcs();
    exercise(9'b0_0000_0001, 15);
    @(negedge clock);
    total++;
    if (bus.Exc_Timeout !== 1'b0) begin
      bad++;
      $display("FAIL ack_at_timeout got to=%b exp=0", bus.Exc_Timeout);
    end
    tick();
  endtask

  task automatic test_random();
    logic [8:0] fl;
    for (int n = 0; n < 40; n++) begin
      randomize_pcs();
      if ($urandom_range(0, 1) == 1) fl = 9'(1 << $urandom_range(0, 8));
      else                           fl = 9'($urandom_range(1, 511));
      exercise(fl, int'($urandom_range(0, 6)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.Exc_Ack = 1'($urandom_range(0, 1));
        @(negedge clock);
        total++;
        if (bus.Exc_Req !== 1'b0 || debug_state !== ST_IDLE) begin
          bad++;
          $display("FAIL random_gap got req=%b state=%0d exp 0 0", bus.Exc_Req, debug_state);
        end
        tick();
        bus.Exc_Ack = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.Stall   = 1'b0;
    bus.Exc_Ack = 1'b0;
    for (int s = 0; s < 4; s++) begin
      stage_pc[s] = 32'h0;
      stage_bd[s] = 1'b0;
    end
    apply_inputs(9'h0);
    test_reset();
    test_idle_ack();
    test_directed();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_commit();
    test_ack_at_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
